uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- UART receive-side controller for the LSU's UART peripheral; the counterpart of the tx path.
- Synchronises the serial rx line, detects start bits with 16x oversampling, deserialises 8N1 frames LSB-first, and pushes each good byte into the RX FIFO with a one-cycle write_en.
- Pushes are gated by the FIFO full flag; framing and overrun conditions are reported to the LSU status register.

Parameters:
BAUD_DIV, 27, clk cycles per oversample tick (50 MHz / 115200 / 16); legal range >= 2
DATA_BITS, 8, data bits per frame; rx_data width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
rx  input  1  serial line, idle high, asynchronous to clk
fifo_full  input  1  RX FIFO full flag
err_clr  input  1  one-cycle pulse clearing sticky overrun and frame_err
rx_data  output  DATA_BITS  received byte, valid while write_en=1
write_en  output  1  one-cycle push strobe to RX FIFO
busy  output  1  high from start-bit detection until return to IDLE
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: good byte dropped because fifo_full=1

Behaviour:
- Reset (reset=0, async) values: write_en=0, busy=0, frame_err=0, overrun=0, rx_data=0, state=IDLE, synchroniser flops=1, counters=0. Reset asserted mid-frame aborts the frame; nothing is pushed.
- rx goes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Tick generator: counter 0..BAUD_DIV-1; tick=1 for one clk when it wraps. Free-running, reset to 0.
- sample_cnt (4 bits) counts ticks within a bit; bit_cnt counts data bits.
- FSM states and transitions:
  - IDLE: busy=0. On rx_s=0, go to START and clear sample_cnt.
  - START: on tick, increment sample_cnt. At sample_cnt=7 (mid-bit): if rx_s=0, go to DATA and clear sample_cnt/bit_cnt; if rx_s=1, treat as a glitch and return to IDLE with no flags.
  - DATA: on tick, sample at sample_cnt=15, i.e. 16 ticks after the previous mid-point. Shift rx_s into the MSB of the shift register (right shift, LSB-first). After DATA_BITS samples, go to STOP.
  - STOP: at the 16th tick, sample the stop bit.
    - rx_s=1 and fifo_full=0: write_en=1 for exactly one clk, rx_data=shift register.
    - rx_s=1 and fifo_full=1: no write_en; overrun<=1.
    - rx_s=0: no write_en; frame_err<=1.
    - In all three cases go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering.
- busy=1 in START, DATA, STOP and WAIT_IDLE.
- rx_data holds its value until the next successful push.
- Latency: write_en rises about 9.5 bit periods plus 2 synchroniser clks after the rx falling edge. One bit period = 16*BAUD_DIV clk.
- fifo_full is sampled only in the same cycle as the stop-bit decision; no retry or buffering.
- Sticky flags:
  - Set has priority over err_clr in the same cycle.
  - frame_err and overrun are never set together for one frame.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}
  - localparams OVERSAMPLE=16 and MID_SAMPLE=7
- One sub-module: uart_baud_tick (BAUD_DIV parameter, clk/reset in, tick out), reusable by the tx path.

Test Plan (BAUD_DIV=4, so bit period = 64 clk):
- Send 0xA5 (8N1), fifo_full=0 -> exactly one write_en pulse with rx_data=0xA5, about 610 clk after the start edge; frame_err=0, overrun=0, busy low again after the stop bit.
- rx low for 20 clk, then high -> no write_en; busy drops within 40 clk; flags stay 0.
- Send 0x3C with the stop bit driven 0, then hold rx low for 200 clk -> no write_en; frame_err=1; busy stays 1 until rx returns high; err_clr pulse -> frame_err=0.
- Send 0x7E with fifo_full=1 during the stop bit -> no write_en; overrun=1 and stays 1 until err_clr; rx_data keeps its previous value.
- Back-to-back 0x00 then 0xFF with no idle gap -> two write_en pulses, 640 clk apart, with data 0x00 then 0xFF.
- Assert reset=0 during data bit 4 of 0x55 -> all outputs at reset values immediately; after release, the next frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and oversampling constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick, one clk wide every BAUD_DIV clks
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(BAUD_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 8N1 UART receiver with 16x oversampling, FIFO push and sticky error flags
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 fifo_full,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 write_en,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BW = $clog2(DATA_BITS + 1);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 tick;
    logic [3:0]           sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // err_clr is applied first so a same-cycle set below takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rx_data    <= '0;
            write_en   <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            write_en <= 1'b0;
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state      <= START;
                        sample_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == 4'(MID_SAMPLE)) begin
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sample_cnt == 4'(OVERSAMPLE - 1)) begin
                            sample_cnt <= '0;
                            shift      <= {rx_s, shift[DATA_BITS-1:1]};
                            bit_cnt    <= bit_cnt + 1'b1;
                            if (bit_cnt == BW'(DATA_BITS - 1))
                                state <= STOP;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (sample_cnt == 4'(OVERSAMPLE - 1)) begin
                            sample_cnt <= '0;
                            state      <= WAIT_IDLE;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                write_en <= 1'b1;
                                rx_data  <= shift;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must not look like a new start bit.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with a frame-level reference model
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int BAUD_DIV = 4;
    localparam int BIT_CLK  = 16 * BAUD_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       fifo_full = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       write_en;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_ctrl #(.BAUD_DIV(BAUD_DIV), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .fifo_full (fifo_full),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .write_en  (write_en),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         last_push = -1;
    int         prev_push = -1;
    bit         we_prev = 1'b0;
    bit         exp_fe = 1'b0;
    bit         exp_ov = 1'b0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a frame's outcome depends only on its stop bit and the FIFO state.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit full, input bit hold_low);
        if (stop_ok && !full) begin
            exp_q.push_back('{data: d, t0: cyc});
            last_good = d;
        end else if (stop_ok) begin
            exp_ov = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT_CLK);
        end
        rx = stop_ok;
        fifo_full = full;
        wait_clk(BIT_CLK);
        fifo_full = 1'b0;
        rx = hold_low ? 1'b0 : 1'b1;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_frame_err"}, frame_err, exp_fe);
        chk({tag, "_overrun"}, overrun, exp_ov);
        chk({tag, "_rx_data"}, rx_data, last_good);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        wait_clk(1);
    endtask

    always @(negedge clk) begin
        if (reset && write_en) begin
            chk("push_single_cycle", we_prev, 1'b0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_push: got data %0h expected no push (cycle %0d)", rx_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("push_data", rx_data, e.data);
                chk("push_latency_in_window", ((cyc - e.t0) >= 604 && (cyc - e.t0) <= 622), 1'b1);
            end
            prev_push = last_push;
            last_push = cyc;
        end
        we_prev = write_en;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_write_en", write_en, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        chk("reset_rx_data", rx_data, 8'h00);
        wait_clk(5);
        reset = 1'b1;
        wait_clk(20);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_clk(10);
        check_flags("a5");
        chk("a5_busy_low", busy, 1'b0);

        rx = 1'b0;
        wait_clk(10);
        chk("glitch_busy_high", busy, 1'b1);
        wait_clk(10);
        rx = 1'b1;
        wait_clk(40);
        chk("glitch_busy_low", busy, 1'b0);
        check_flags("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_clk(200);
        chk("break_busy_high", busy, 1'b1);
        check_flags("break");
        rx = 1'b1;
        wait_clk(10);
        chk("break_busy_low", busy, 1'b0);
        clear_flags();
        check_flags("break_cleared");

        send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
        wait_clk(10);
        check_flags("ovr");
        wait_clk(100);
        chk("ovr_sticky", overrun, 1'b1);
        clear_flags();
        check_flags("ovr_cleared");

        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        wait_clk(20);
        chk("b2b_spacing_in_window", ((last_push - prev_push) >= 632 && (last_push - prev_push) <= 648), 1'b1);
        check_flags("b2b");

        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h55 >> i) & 1'b1;
            wait_clk(BIT_CLK);
        end
        rx = 1'b1;
        wait_clk(BIT_CLK / 2);
        reset = 1'b0;
        #1;
        last_good = 8'h00;
        chk("midreset_write_en", write_en, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_frame_err", frame_err, 1'b0);
        chk("midreset_overrun", overrun, 1'b0);
        chk("midreset_rx_data", rx_data, 8'h00);
        wait_clk(5);
        reset = 1'b1;
        wait_clk(20);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        wait_clk(10);
        check_flags("after_reset");

        for (int n = 0; n < 10; n++) begin
            logic [7:0] d;
            int         mode;
            d = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 3);
            send_frame(d, mode != 2, mode == 3, 1'b0);
            wait_clk(10 + $urandom_range(0, 30));
            check_flags("rand");
            chk("rand_busy_low", busy, 1'b0);
            if (exp_fe || exp_ov) clear_flags();
        end

        wait_clk(10);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
